// File: rtl/io_pinmux_ctrl.sv
// Wishbone-programmable pad multiplexer: routes each pad to one of four functions, with a tri-state guard on every select change.
// Ports: wb_clk_i/wb_rst_i clock and reset; wbs_* Wishbone slave; func_out/func_oeb/func_in per-function pad signals (bit f*NPADS+p); io_in/io_out/io_oeb pads.
// Latency: one-cycle registered ack per access; a select change tri-states the pad for GUARD cycles before the new function drives.
module io_pinmux_ctrl #(
    parameter int   NPADS   = 38,
    parameter int   GUARD   = 4,
    parameter logic IDLE_IN = 1'b0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    input  logic [4*NPADS-1:0]   func_out,
    input  logic [4*NPADS-1:0]   func_oeb,
    output logic [4*NPADS-1:0]   func_in,
    input  logic [NPADS-1:0]     io_in,
    output logic [NPADS-1:0]     io_out,
    output logic [NPADS-1:0]     io_oeb
);

    localparam logic [3:0] GUARD_LD = 4'(GUARD);

    logic [1:0]       act_sel_q  [NPADS];
    logic [1:0]       pend_sel_q [NPADS];
    logic [3:0]       gcnt_q     [NPADS];
    logic             lock_q;
    logic             ack_q;
    logic [31:0]      dat_q;

    logic [5:0]       word;
    logic             bus_req;
    logic             wr_en;
    logic [31:0]      rd_dat_d;
    logic [NPADS-1:0] wr_hit;
    logic [1:0]       wr_val     [NPADS];
    logic [NPADS-1:0] in_guard;
    logic             unused_adr;

    assign word       = wbs_adr_i[7:2];
    assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};
    // Ack low is part of the request so a held strobe is acked every other cycle.
    assign bus_req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign wr_en      = bus_req & wbs_we_i;

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;

    // Per-pad write decode: pad p lives in word p/16, field p%16, byte lane (p%16)/4.
    always_comb begin
        for (int p = 0; p < NPADS; p++) begin
            wr_val[p] = wbs_dat_i[2*(p%16) +: 2];
            wr_hit[p] = wr_en && !lock_q && (word == 6'(p/16)) && wbs_sel_i[(p%16)/4];
        end
    end

    always_comb begin
        rd_dat_d = '0;
        if (word < 6'd4) begin
            for (int p = 0; p < NPADS; p++) begin
                if (word == 6'(p/16)) begin
                    rd_dat_d[2*(p%16) +: 2] = pend_sel_q[p];
                end
            end
        end else if (word == 6'd14) begin
            rd_dat_d[0] = |in_guard;
        end else if (word == 6'd15) begin
            rd_dat_d[0] = lock_q;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            ack_q <= bus_req;
            dat_q <= (bus_req && !wbs_we_i) ? rd_dat_d : 32'd0;
            if (wr_en && (word == 6'd15) && wbs_sel_i[0] && wbs_dat_i[0]) begin
                lock_q <= 1'b1;
            end
        end
    end

    // A write wins over a same-cycle guard expiry: it reloads the counter and
    // the committed function stays put. Rewriting the pending value while idle
    // is a no-op, but any write during a guard restarts it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int p = 0; p < NPADS; p++) begin
                act_sel_q[p]  <= 2'd0;
                pend_sel_q[p] <= 2'd0;
                gcnt_q[p]     <= 4'd0;
            end
        end else begin
            for (int p = 0; p < NPADS; p++) begin
                if (wr_hit[p] && ((wr_val[p] != pend_sel_q[p]) || (gcnt_q[p] != 4'd0))) begin
                    pend_sel_q[p] <= wr_val[p];
                    gcnt_q[p]     <= GUARD_LD;
                    if (GUARD == 0) begin
                        act_sel_q[p] <= wr_val[p];
                    end
                end else if (gcnt_q[p] != 4'd0) begin
                    gcnt_q[p] <= gcnt_q[p] - 4'd1;
                    if (gcnt_q[p] == 4'd1) begin
                        act_sel_q[p] <= pend_sel_q[p];
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NPADS; p++) begin : g_pad
        logic [3:0] fo;
        logic [3:0] fe;

        assign in_guard[p] = (gcnt_q[p] != 4'd0);
        assign fo = {func_out[3*NPADS+p], func_out[2*NPADS+p], func_out[NPADS+p], func_out[p]};
        assign fe = {func_oeb[3*NPADS+p], func_oeb[2*NPADS+p], func_oeb[NPADS+p], func_oeb[p]};

        assign io_out[p] = in_guard[p] ? 1'b0 : fo[act_sel_q[p]];
        assign io_oeb[p] = in_guard[p] | fe[act_sel_q[p]];

        for (genvar f = 0; f < 4; f++) begin : g_fin
            assign func_in[f*NPADS+p] = (!in_guard[p] && (act_sel_q[p] == 2'(f))) ? io_in[p] : IDLE_IN;
        end
    end

endmodule

// File: tb/tb_io_pinmux_ctrl.sv
module tb_io_pinmux_ctrl;
    localparam int NP = 38;
    localparam int G  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stb, cyc, we;
    logic [3:0]       sel;
    logic [31:0]      adr, dat_w;
    logic             ack;
    logic [31:0]      dat_r;
    logic [4*NP-1:0]  func_out, func_oeb, func_in;
    logic [NP-1:0]    io_in, io_out, io_oeb;

    always #5 clk = ~clk;

    io_pinmux_ctrl #(.NPADS(NP), .GUARD(G), .IDLE_IN(1'b0)) dut (
        .wb_clk_i (clk),      .wb_rst_i (rst),
        .wbs_stb_i(stb),      .wbs_cyc_i(cyc),      .wbs_we_i (we),
        .wbs_sel_i(sel),      .wbs_adr_i(adr),      .wbs_dat_i(dat_w),
        .wbs_ack_o(ack),      .wbs_dat_o(dat_r),
        .func_out (func_out), .func_oeb (func_oeb), .func_in  (func_in),
        .io_in    (io_in),    .io_out   (io_out),   .io_oeb   (io_oeb)
    );

    // Reference model: each pad remembers its last effective write time, the
    // written value and the function in force before it. Everything else
    // (guard, driving function) follows from elapsed edges.
    int pend_m [NP];
    int prev_m [NP];
    int wr_m   [NP];
    int tcount;
    bit lock_m, ack_m, rand_io;
    int checks, errors;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            pend_m[p] = 0; prev_m[p] = 0; wr_m[p] = -100000;
        end
        lock_m = 0; ack_m = 0;
    endtask

    function automatic int act_m(int p);
        return (tcount - wr_m[p] >= G) ? pend_m[p] : prev_m[p];
    endfunction

    function automatic bit guard_m(int p);
        return (tcount - wr_m[p]) < G;
    endfunction

    task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] s);
        int q, nv;
        if (w < 4 && !lock_m) begin
            for (int p = 0; p < NP; p++) begin
                if (p / 16 == w) begin
                    q = p % 16;
                    if (s[q/4]) begin
                        nv = int'((d >> (2*q)) & 32'd3);
                        if (nv != pend_m[p] || guard_m(p)) begin
                            prev_m[p] = act_m(p);
                            pend_m[p] = nv;
                            wr_m[p]   = tcount + 1;
                        end
                    end
                end
            end
        end
        if (w == 15 && s[0] && d[0]) lock_m = 1;
    endtask

    function automatic logic [31:0] rd_exp(int w);
        logic [31:0] r = '0;
        if (w < 4) begin
            for (int p = 0; p < NP; p++)
                if (p / 16 == w) r[2*(p%16) +: 2] = 2'(pend_m[p]);
        end else if (w == 14) begin
            for (int p = 0; p < NP; p++) if (guard_m(p)) r[0] = 1'b1;
        end else if (w == 15) begin
            r[0] = lock_m;
        end
        return r;
    endfunction

    task automatic check_pads();
        logic [NP-1:0]   eo, eoeb;
        logic [4*NP-1:0] efi;
        int a;
        efi = '0;
        for (int p = 0; p < NP; p++) begin
            a = act_m(p);
            if (guard_m(p)) begin
                eo[p] = 1'b0; eoeb[p] = 1'b1;
            end else begin
                eo[p]   = func_out[a*NP+p];
                eoeb[p] = func_oeb[a*NP+p];
                efi[a*NP+p] = io_in[p];
            end
        end
        chk("io_out", io_out, eo);
        chk("io_oeb", io_oeb, eoeb);
        chk("func_in", func_in, efi);
    endtask

    task automatic drive_rand();
        for (int i = 0; i < 4*NP; i++) begin
            func_out[i] = 1'($urandom_range(0, 1));
            func_oeb[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < NP; i++) io_in[i] = 1'($urandom_range(0, 1));
    endtask

    // One clock: model the edge, then check everything on the falling edge.
    task automatic step();
        @(posedge clk);
        if (stb && cyc && !ack_m) begin
            if (we) model_write(int'(adr[7:2]), dat_w, sel);
            ack_m = 1;
        end else begin
            ack_m = 0;
        end
        tcount++;
        @(negedge clk);
        check_pads();
        chk("ack", ack, ack_m);
        if (!ack_m) chk("dat_idle", dat_r, 32'd0);
        if (rand_io) drive_rand();
    endtask

    task automatic bus_idle();
        stb = 0; cyc = 0; we = 0; sel = 4'h0; adr = '0; dat_w = '0;
    endtask

    task automatic wb_wr(input int w, input logic [31:0] d, input logic [3:0] s);
        stb = 1; cyc = 1; we = 1; sel = s; adr = 32'(w) << 2; dat_w = d;
        step();
        bus_idle();
        step();
    endtask

    task automatic wb_rd(input int w, input string tag, output logic [31:0] got);
        logic [31:0] e;
        e = rd_exp(w);
        stb = 1; cyc = 1; we = 0; sel = 4'hF; adr = 32'(w) << 2; dat_w = '0;
        step();
        got = dat_r;
        chk(tag, got, e);
        bus_idle();
        step();
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rv, w0;
        logic [NP-1:0] pat_a;
        int w;
        checks = 0; errors = 0; tcount = 0; rand_io = 0;
        bus_idle();
        model_reset();
        drive_rand();
        for (int p = 0; p < NP; p++) func_oeb[p] = 1'b0;
        pat_a = func_out[NP-1:0];

        // Reset state: pads follow function 0 during and after reset.
        repeat (2) @(negedge clk);
        chk("rst_io_out", io_out, pat_a);
        chk("rst_io_oeb", io_oeb, '0);
        chk("rst_ack", ack, 1'b0);
        chk("rst_dat", dat_r, 32'd0);
        rst = 0;
        @(negedge clk);
        chk("post_rst_io_out", io_out, pat_a);
        for (int i = 0; i < 4; i++) begin
            wb_rd(i, "rst_sel_rd", rv);
            chk("rst_sel_zero", rv, 32'd0);
        end
        rand_io = 1;

        // Single switch of pad 5 to function 2, then restart the guard with function 3.
        wb_wr(0, 32'h0000_0800, 4'hF);
        chk("sw_guard_oeb5", io_oeb[5], 1'b1);
        repeat (4) step();
        wb_wr(0, 32'h0000_0800, 4'hF);
        wb_wr(0, 32'h0000_0C00, 4'hF);
        repeat (2) step();
        chk("restart_guard_oeb5", io_oeb[5], 1'b1);
        repeat (4) step();
        chk("restart_out5", io_out[5], func_out[3*NP+5]);

        // Byte lanes.
        wb_wr(1, 32'hFFFF_FFFF, 4'b0001);
        wb_rd(1, "lane_rd_w1", rv);
        chk("lane_w1_const", rv, 32'h0000_00FF);
        wb_wr(2, 32'hFFFF_FFFF, 4'hF);
        wb_rd(2, "lane_rd_w2", rv);
        chk("lane_w2_const", rv, 32'h0000_0FFF);

        // Randomized traffic over SEL, STATUS and an unmapped word.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: w = 0; 1: w = 1; 2: w = 2; 3: w = 3; 4: w = 14; default: w = 7;
            endcase
            if ($urandom_range(0, 1) == 1)
                wb_wr(w, $urandom, 4'($urandom_range(0, 15)));
            else
                wb_rd(w, "rand_rd", rv);
            repeat ($urandom_range(0, 4)) step();
        end
        repeat (6) step();

        // Lock freezes the map.
        wb_rd(0, "pre_lock_w0", w0);
        wb_wr(15, 32'd1, 4'hF);
        wb_wr(0, 32'hFFFF_FFFF, 4'hF);
        wb_rd(14, "lock_status", rv);
        chk("lock_status_zero", rv, 32'd0);
        wb_rd(0, "lock_w0_rd", rv);
        chk("lock_w0_same", rv, w0);
        wb_rd(15, "lock_rd", rv);
        chk("lock_set", rv, 32'd1);

        // Reset during a guard.
        do_reset();
        @(negedge clk);
        wb_wr(0, 32'h0000_0800, 4'hF);
        wb_wr(15, 32'd1, 4'h1);
        chk("pre_rst_guard5", io_oeb[5], 1'b1);
        #2;
        rst = 1;
        model_reset();
        #1;
        chk("midrst_oeb5", io_oeb[5], func_oeb[5]);
        chk("midrst_out5", io_out[5], func_out[5]);
        check_pads();
        @(negedge clk);
        rst = 0;
        wb_rd(15, "post_rst_lock", rv);
        chk("post_rst_lock_zero", rv, 32'd0);
        wb_rd(0, "post_rst_w0", rv);
        chk("post_rst_w0_zero", rv, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
